// File: rtl/av2_pkg.sv
// Shared types and constants for the AV2 frame-level decode controller.
// Imported by the interface, the raster generator and the top.
package av2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FEED_HDR = 3'd1,
    ST_WAIT_HDR = 3'd2,
    ST_SETUP    = 3'd3,
    ST_DISPATCH = 3'd4,
    ST_DRAIN    = 3'd5,
    ST_DONE     = 3'd6,
    ST_ERROR    = 3'd7
  } state_e;

  localparam logic [1:0] KEY_FRAME   = 2'd0;
  localparam logic [1:0] INTER_FRAME = 2'd1;
  localparam logic [1:0] INTRA_ONLY  = 2'd2;
  localparam logic [1:0] SWITCH      = 2'd3;

  localparam int SB_SIZE_LOG2_DEF = 6;

endpackage

// File: rtl/av2_frame_decode_ctrl_if.sv
// Bundle of all controller-facing signals: OBU stream, header parser,
// SB job issue and frame status. slave = controller, master = environment.
interface av2_frame_decode_ctrl_if #(
  parameter int SB_IDX_W = 11
);
  logic                start;
  logic                obu_valid_in;
  logic [127:0]        obu_data_in;
  logic                obu_ready_out;
  logic                hdr_obu_valid;
  logic [127:0]        hdr_obu_data;
  logic                hdr_valid;
  logic [1:0]          hdr_frame_type;
  logic [15:0]         hdr_width;
  logic [15:0]         hdr_height;
  logic [7:0]          hdr_qindex;
  logic                hdr_ready;
  logic                sb_req_valid;
  logic [SB_IDX_W-1:0] sb_req_x;
  logic [SB_IDX_W-1:0] sb_req_y;
  logic [7:0]          sb_req_qindex;
  logic                sb_req_ready;
  logic                sb_done;
  logic                busy;
  logic [1:0]          cur_frame_type;
  logic                frame_done;
  logic                frame_error;

  modport slave (
    input  start, obu_valid_in, obu_data_in,
    input  hdr_valid, hdr_frame_type, hdr_width,
    input  hdr_height, hdr_qindex,
    input  sb_req_ready, sb_done,
    output obu_ready_out, hdr_obu_valid, hdr_obu_data,
    output hdr_ready, sb_req_valid, sb_req_x,
    output sb_req_y, sb_req_qindex, busy,
    output cur_frame_type, frame_done, frame_error
  );

  modport master (
    output start, obu_valid_in, obu_data_in,
    output hdr_valid, hdr_frame_type, hdr_width,
    output hdr_height, hdr_qindex,
    output sb_req_ready, sb_done,
    input  obu_ready_out, hdr_obu_valid, hdr_obu_data,
    input  hdr_ready, sb_req_valid, sb_req_x,
    input  sb_req_y, sb_req_qindex, busy,
    input  cur_frame_type, frame_done, frame_error
  );

endinterface

// File: rtl/av2_sb_raster_gen.sv
// Superblock grid sizing and raster-order x/y walker.
// Grid size is a ceil-divide of the latched frame dimensions.
module av2_sb_raster_gen
  import av2_pkg::*;
#(
  parameter int SB_SIZE_LOG2 = SB_SIZE_LOG2_DEF,
  parameter int SB_IDX_W     = 16 - SB_SIZE_LOG2 + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [15:0]         width_i,
  input  logic [15:0]         height_i,
  input  logic                load_i,
  input  logic                adv_i,
  output logic [SB_IDX_W-1:0] x_o,
  output logic [SB_IDX_W-1:0] y_o,
  output logic                last_o,
  output logic                zero_o
);

  localparam logic [16:0] RND = 17'((1 << SB_SIZE_LOG2) - 1);

  logic [SB_IDX_W-1:0] cols;
  logic [SB_IDX_W-1:0] rows;
  logic [SB_IDX_W-1:0] x_q, x_d;
  logic [SB_IDX_W-1:0] y_q, y_d;
  logic                x_end;
  logic                y_end;

  // 17-bit sum so a 65535-pixel edge still rounds up correctly
  assign cols = SB_IDX_W'(({1'b0, width_i} + RND) >> SB_SIZE_LOG2);
  assign rows = SB_IDX_W'(({1'b0, height_i} + RND) >> SB_SIZE_LOG2);

  assign x_end  = (x_q == cols - 1'b1);
  assign y_end  = (y_q == rows - 1'b1);
  assign last_o = x_end && y_end;
  assign zero_o = (cols == '0) || (rows == '0);
  assign x_o    = x_q;
  assign y_o    = y_q;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (load_i) begin
      x_d = '0;
      y_d = '0;
    end else if (adv_i) begin
      if (x_end) begin
        x_d = '0;
        y_d = y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule

// File: rtl/av2_frame_decode_ctrl.sv
// Frame sequencer: header OBU to parser, header latch, SB job issue
// with bounded outstanding jobs, completion/error reporting.
module av2_frame_decode_ctrl
  import av2_pkg::*;
#(
  parameter int SB_SIZE_LOG2    = SB_SIZE_LOG2_DEF,
  parameter int MAX_OUTSTANDING = 4,
  parameter int HDR_TIMEOUT     = 1024,
  parameter int SB_IDX_W        = 16 - SB_SIZE_LOG2 + 1
) (
  input logic                    clk,
  input logic                    rst_n,
  av2_frame_decode_ctrl_if.slave bus
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int TW = $clog2(HDR_TIMEOUT + 1);
  localparam logic [OW-1:0] OUT_MAX  = OW'(MAX_OUTSTANDING);
  localparam logic [TW-1:0] TMO_LAST = TW'(HDR_TIMEOUT - 1);

  state_e        state_q;
  logic          obu_vld_q;
  logic [127:0]  obu_dat_q;
  logic [TW-1:0] tmo_q;
  logic [1:0]    type_q;
  logic [15:0]   width_q;
  logic [15:0]   height_q;
  logic [7:0]    qidx_q;
  logic [1:0]    ftype_q;
  logic          done_q;
  logic          err_q;
  logic [OW-1:0] out_q, out_d;

  logic                req_vld;
  logic                hs;
  logic                dec;
  logic                active;
  logic [SB_IDX_W-1:0] rg_x;
  logic [SB_IDX_W-1:0] rg_y;
  logic                rg_last;
  logic                rg_zero;

  assign active  = (state_q == ST_DISPATCH) || (state_q == ST_DRAIN);
  assign req_vld = (state_q == ST_DISPATCH) && (out_q < OUT_MAX);
  assign hs      = req_vld && bus.sb_req_ready;
  assign dec     = bus.sb_done && (out_q != '0);

  av2_sb_raster_gen #(
    .SB_SIZE_LOG2 (SB_SIZE_LOG2),
    .SB_IDX_W     (SB_IDX_W)
  ) u_raster (
    .clk      (clk),
    .rst_n    (rst_n),
    .width_i  (width_q),
    .height_i (height_q),
    .load_i   (state_q == ST_SETUP),
    .adv_i    (hs),
    .x_o      (rg_x),
    .y_o      (rg_y),
    .last_o   (rg_last),
    .zero_o   (rg_zero)
  );

  always_comb begin
    out_d = out_q;
    if (state_q == ST_ERROR) begin
      out_d = '0;
    end else if (active) begin
      out_d = out_q + OW'(hs) - OW'(dec);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      obu_vld_q <= 1'b0;
      obu_dat_q <= '0;
      tmo_q     <= '0;
      type_q    <= '0;
      width_q   <= '0;
      height_q  <= '0;
      qidx_q    <= '0;
      ftype_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start) state_q <= ST_FEED_HDR;
        end
        ST_FEED_HDR: begin
          if (bus.obu_valid_in) begin
            obu_dat_q <= bus.obu_data_in;
            obu_vld_q <= 1'b1;
            tmo_q     <= '0;
            state_q   <= ST_WAIT_HDR;
          end
        end
        ST_WAIT_HDR: begin
          tmo_q <= tmo_q + 1'b1;
          if (bus.hdr_valid) begin
            type_q    <= bus.hdr_frame_type;
            width_q   <= bus.hdr_width;
            height_q  <= bus.hdr_height;
            qidx_q    <= bus.hdr_qindex;
            obu_vld_q <= 1'b0;
            state_q   <= ST_SETUP;
          end else if (tmo_q == TMO_LAST) begin
            obu_vld_q <= 1'b0;
            err_q     <= 1'b1;
            state_q   <= ST_ERROR;
          end
        end
        ST_SETUP: begin
          ftype_q <= type_q;
          if (rg_zero) begin
            err_q   <= 1'b1;
            state_q <= ST_ERROR;
          end else begin
            state_q <= ST_DISPATCH;
          end
        end
        ST_DISPATCH: begin
          if (hs && rg_last) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (out_d == '0) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE:  state_q <= ST_IDLE;
        ST_ERROR: state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.obu_ready_out  = (state_q == ST_FEED_HDR);
  assign bus.hdr_ready      = (state_q == ST_WAIT_HDR);
  assign bus.hdr_obu_valid  = obu_vld_q;
  assign bus.hdr_obu_data   = obu_dat_q;
  assign bus.sb_req_valid   = req_vld;
  assign bus.sb_req_x       = rg_x;
  assign bus.sb_req_y       = rg_y;
  assign bus.sb_req_qindex  = qidx_q;
  assign bus.busy           = (state_q != ST_IDLE);
  assign bus.cur_frame_type = ftype_q;
  assign bus.frame_done     = done_q;
  assign bus.frame_error    = err_q;

endmodule

// File: tb/tb_av2_frame_decode_ctrl.sv
// Bench for av2_frame_decode_ctrl: frame vector table, random frames
// against a job-list model, header timeout and mid-frame reset.
module tb_av2_frame_decode_ctrl;
  import av2_pkg::*;

  localparam int MAXO = 4;
  localparam int TMO  = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  av2_frame_decode_ctrl_if #(.SB_IDX_W(11)) bus ();

  av2_frame_decode_ctrl #(
    .SB_SIZE_LOG2    (6),
    .MAX_OUTSTANDING (MAXO),
    .HDR_TIMEOUT     (TMO),
    .SB_IDX_W        (11)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // mode: 0 done 3 cycles after accept, 1 random, 2 done withheld,
  // 3 ready/done on alternating cycles
  typedef struct {
    int w;
    int h;
    int q;
    int ft;
    int cols;
    int rows;
    int mode;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed_header(input int w, input int h,
                             input int q, input int ft);
    logic [127:0] d;
    d = {$urandom, $urandom, $urandom, $urandom};
    chk("idle_busy", bus.busy, 0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("feed_ready", bus.obu_ready_out, 1);
    chk("feed_busy", bus.busy, 1);
    chk("feed_hdr_ready", bus.hdr_ready, 0);
    tick();
    chk("feed_hold", bus.obu_ready_out, 1);
    bus.obu_valid_in = 1'b1;
    bus.obu_data_in  = d;
    tick();
    bus.obu_valid_in = 1'b0;
    bus.obu_data_in  = '0;
    for (int i = 0; i < 3; i++) begin
      chk("hdr_obu_valid", bus.hdr_obu_valid, 1);
      chk("hdr_obu_data", bus.hdr_obu_data, d);
      chk("hdr_ready", bus.hdr_ready, 1);
      chk("wait_obu_ready", bus.obu_ready_out, 0);
      if (i == 2) begin
        bus.hdr_valid      = 1'b1;
        bus.hdr_width      = 16'(w);
        bus.hdr_height     = 16'(h);
        bus.hdr_qindex     = 8'(q);
        bus.hdr_frame_type = 2'(ft);
      end
      tick();
    end
    bus.hdr_valid      = 1'b0;
    bus.hdr_width      = 16'($urandom);
    bus.hdr_height     = 16'($urandom);
    bus.hdr_qindex     = 8'($urandom);
    bus.hdr_frame_type = 2'($urandom);
    chk("setup_obu_drop", bus.hdr_obu_valid, 0);
    chk("setup_no_req", bus.sb_req_valid, 0);
  endtask

  task automatic run_frame(input vec_t v);
    int jx[$];
    int jy[$];
    int acc[$];
    int pend;
    int obs;
    bit fin;
    bit ev;
    logic rdy;
    logic dn;
    pend = 0;
    obs  = 0;
    fin  = 1'b0;
    feed_header(v.w, v.h, v.q, v.ft);
    tick();
    if (v.cols == 0 || v.rows == 0) begin
      chk("err_pulse", bus.frame_error, 1);
      chk("err_type", bus.cur_frame_type, v.ft);
      chk("err_no_req", bus.sb_req_valid, 0);
      tick();
      chk("err_idle", bus.busy, 0);
      chk("err_once", bus.frame_error, 0);
      return;
    end
    chk("frame_type", bus.cur_frame_type, v.ft);
    for (int y = 0; y < v.rows; y++)
      for (int x = 0; x < v.cols; x++) begin
        jx.push_back(x);
        jy.push_back(y);
      end
    for (int c = 0; c < 20000 && !fin; c++) begin
      ev = (jx.size() > 0) && (pend < MAXO);
      chk("req_valid", bus.sb_req_valid, ev);
      chk("done_early", bus.frame_done, 0);
      chk("busy_run", bus.busy, 1);
      if (ev && bus.sb_req_valid) begin
        chk("req_x", bus.sb_req_x, jx[0]);
        chk("req_y", bus.sb_req_y, jy[0]);
        chk("req_q", bus.sb_req_qindex, v.q);
      end
      rdy = 1'b1;
      dn  = 1'b0;
      case (v.mode)
        0: dn = (acc.size() > 0) && (c - acc[0] >= 3);
        1: begin
          rdy = ($urandom % 4) != 0;
          dn  = (pend > 0) && (($urandom % 3) == 0);
          bus.start = 1'($urandom);
        end
        2: dn = (pend > 0) && (c == 12 || c >= 24);
        default: begin
          rdy = 1'(c % 2);
          dn  = (pend > 0) && (c % 2 == 1);
        end
      endcase
      if (v.mode == 0 && dn) void'(acc.pop_front());
      bus.sb_req_ready = rdy;
      bus.sb_done      = dn;
      if (bus.sb_req_valid && rdy) obs++;
      tick();
      if (ev && rdy) begin
        void'(jx.pop_front());
        void'(jy.pop_front());
        pend++;
        if (v.mode == 0) acc.push_back(c);
      end
      if (dn) pend--;
      if (v.mode == 2 && c == 20) chk("held_accepts", obs, 5);
      if (jx.size() == 0 && pend == 0) fin = 1'b1;
    end
    bus.start        = 1'b0;
    bus.sb_req_ready = 1'b0;
    bus.sb_done      = 1'b0;
    if (!fin) begin
      chk("frame_budget", 0, 1);
      return;
    end
    chk("frame_done", bus.frame_done, 1);
    chk("done_busy", bus.busy, 1);
    chk("done_no_req", bus.sb_req_valid, 0);
    tick();
    chk("done_once", bus.frame_done, 0);
    chk("done_idle", bus.busy, 0);
  endtask

  initial begin
    vec_t rv;
    rst_n            = 1'b0;
    bus.start        = 1'b0;
    bus.obu_valid_in = 1'b0;
    bus.obu_data_in  = '0;
    bus.hdr_valid    = 1'b0;
    bus.hdr_frame_type = '0;
    bus.hdr_width    = '0;
    bus.hdr_height   = '0;
    bus.hdr_qindex   = '0;
    bus.sb_req_ready = 1'b0;
    bus.sb_done      = 1'b0;

    vecs.push_back('{64, 64, 32, KEY_FRAME, 1, 1, 0});
    vecs.push_back('{130, 70, 77, INTER_FRAME, 3, 2, 0});
    vecs.push_back('{130, 70, 5, INTRA_ONLY, 3, 2, 2});
    vecs.push_back('{130, 70, 200, SWITCH, 3, 2, 3});
    vecs.push_back('{0, 64, 11, INTER_FRAME, 0, 1, 0});
    vecs.push_back('{64, 0, 12, SWITCH, 1, 0, 0});
    vecs.push_back('{65535, 1, 99, KEY_FRAME, 1024, 1, 0});
    vecs.push_back('{1, 65535, 3, INTRA_ONLY, 1, 1024, 0});
    vecs.push_back('{65, 129, 250, INTER_FRAME, 2, 3, 1});

    #12;
    chk("rst_busy", bus.busy, 0);
    chk("rst_obu_ready", bus.obu_ready_out, 0);
    chk("rst_hdr_obu_valid", bus.hdr_obu_valid, 0);
    chk("rst_hdr_obu_data", bus.hdr_obu_data, 0);
    chk("rst_hdr_ready", bus.hdr_ready, 0);
    chk("rst_req_valid", bus.sb_req_valid, 0);
    chk("rst_req_x", bus.sb_req_x, 0);
    chk("rst_req_q", bus.sb_req_qindex, 0);
    chk("rst_ftype", bus.cur_frame_type, 0);
    chk("rst_done", bus.frame_done, 0);
    chk("rst_err", bus.frame_error, 0);
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) run_frame(vecs[i]);

    for (int i = 0; i < 6; i++) begin
      rv.w    = $urandom_range(1, 300);
      rv.h    = $urandom_range(1, 300);
      rv.q    = $urandom_range(0, 255);
      rv.ft   = $urandom_range(0, 3);
      rv.cols = (rv.w + 63) / 64;
      rv.rows = (rv.h + 63) / 64;
      rv.mode = 1;
      run_frame(rv);
    end

    bus.start = 1'b1;
    tick();
    bus.start        = 1'b0;
    bus.obu_valid_in = 1'b1;
    tick();
    bus.obu_valid_in = 1'b0;
    for (int k = 1; k <= TMO; k++) begin
      tick();
      if (k < TMO) begin
        chk("tmo_early", bus.frame_error, 0);
        chk("tmo_hold", bus.hdr_obu_valid, 1);
        chk("tmo_no_req", bus.sb_req_valid, 0);
      end
    end
    chk("tmo_err", bus.frame_error, 1);
    chk("tmo_obu_drop", bus.hdr_obu_valid, 0);
    chk("tmo_no_req_end", bus.sb_req_valid, 0);
    tick();
    chk("tmo_once", bus.frame_error, 0);
    chk("tmo_idle", bus.busy, 0);

    feed_header(130, 70, 9, INTER_FRAME);
    tick();
    bus.sb_req_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    #2;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_req", bus.sb_req_valid, 0);
    chk("mid_rst_x", bus.sb_req_x, 0);
    chk("mid_rst_q", bus.sb_req_qindex, 0);
    chk("mid_rst_data", bus.hdr_obu_data, 0);
    chk("mid_rst_ftype", bus.cur_frame_type, 0);
    bus.sb_req_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("post_rst_done", bus.frame_done, 0);
      chk("post_rst_err", bus.frame_error, 0);
      chk("post_rst_busy", bus.busy, 0);
    end
    run_frame('{130, 70, 44, KEY_FRAME, 3, 2, 0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
